// File: rtl/alarm_timer_sequencer_if.sv
// Purpose: request/status bundle between the alarm FSM (master), the owner
//          reprogramming path, and the alarm timer sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: none; every strobe is accepted in the cycle it is presented.
// Signals: start_timer/interval   load-and-start request, parameter index
//          reprogram/time_param_sel/time_value   parameter bank write
//          expired/one_hz_enable/busy/remaining  timer status back to users
interface alarm_timer_sequencer_if;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_enable;
  logic       busy;
  logic [3:0] remaining;

  modport master (
    output start_timer, interval, reprogram, time_param_sel, time_value,
    input  expired, one_hz_enable, busy, remaining
  );

  modport slave (
    input  start_timer, interval, reprogram, time_param_sel, time_value,
    output expired, one_hz_enable, busy, remaining
  );
endinterface

// File: rtl/alarm_timer_sequencer.sv
// Purpose: shared countdown timer plus the four programmable time parameters
//          of the anti-theft system, paced by an internal 1 Hz enable.
// Latency: expired pulses the cycle after start edge + V*ONE_HZ_DIV (V>0), or
//          the cycle after the start edge when V=0; status outputs are pure
//          register decodes.
// Backpressure: none; start and reprogram strobes are always accepted.
// Ports:   clock, reset (synchronous, active-high)
//          bus (slave modport): start_timer, interval, reprogram,
//          time_param_sel, time_value in; expired, one_hz_enable, busy,
//          remaining out.
module alarm_timer_sequencer #(
  parameter int ONE_HZ_DIV        = 50_000_000,
  parameter int T_ARM_DELAY       = 6,
  parameter int T_DRIVER_DELAY    = 8,
  parameter int T_PASSENGER_DELAY = 15,
  parameter int T_ALARM_ON        = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  alarm_timer_sequencer_if.slave        bus
);

  localparam int                PS_W   = $clog2(ONE_HZ_DIV);
  localparam logic [PS_W-1:0]   PS_MAX = PS_W'(ONE_HZ_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PS_W-1:0]   prescaler_q, prescaler_d;
  logic [3:0]        remaining_q, remaining_d;
  // Packed bank: index 0 arm, 1 driver, 2 passenger, 3 alarm-on.
  logic [3:0][3:0]   params_q, params_d;
  logic              tick;
  logic [3:0]        start_val;

  assign tick      = (prescaler_q == PS_MAX);
  // Read from the registered bank so a same-cycle write is not seen by the start.
  assign start_val = params_q[bus.interval];

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    params_d    = params_q;
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;

    if (bus.reprogram) begin
      params_d[bus.time_param_sel] = bus.time_value;
    end

    if (bus.start_timer) begin
      // Start wins over the tick and over EXPIRE; restarting drops the old run
      // without an expired pulse. Clearing the prescaler makes the first
      // second full length.
      remaining_d = start_val;
      prescaler_d = '0;
      state_d     = (start_val != 4'd0) ? COUNT : EXPIRE;
    end else begin
      unique case (state_q)
        COUNT: begin
          if (tick) begin
            if (remaining_q > 4'd1) begin
              remaining_d = remaining_q - 4'd1;
            end else begin
              remaining_d = 4'd0;
              state_d     = EXPIRE;
            end
          end
        end
        EXPIRE:  state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      remaining_q <= 4'd0;
      params_q    <= {4'(T_ALARM_ON), 4'(T_PASSENGER_DELAY),
                      4'(T_DRIVER_DELAY), 4'(T_ARM_DELAY)};
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      remaining_q <= remaining_d;
      params_q    <= params_d;
    end
  end

  assign bus.one_hz_enable = tick;
  assign bus.busy          = (state_q == COUNT);
  assign bus.expired       = (state_q == EXPIRE);
  assign bus.remaining     = remaining_q;

endmodule

// File: doc/alarm_timer_sequencer.md
Name: alarm_timer_sequencer

Overview:
Owns the shared countdown timer and the four programmable time parameters of the anti-theft system. It loads the interval selected by the alarm FSM into the countdown, paces the countdown with an internally generated 1 Hz enable, and raises a single-cycle `expired` pulse when the count runs out. It also applies owner reprogramming writes to the parameter bank. It sits between the alarm FSM (the `start_timer`/`interval` requester and `expired` consumer) and the siren generator (which consumes `one_hz_enable`).

Parameters:
- ONE_HZ_DIV, 50_000_000, clock cycles per second; must be ≥2.
- T_ARM_DELAY, 6, reset value of parameter 0 (seconds, 4-bit).
- T_DRIVER_DELAY, 8, reset value of parameter 1.
- T_PASSENGER_DELAY, 15, reset value of parameter 2.
- T_ALARM_ON, 10, reset value of parameter 3.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start_timer  in  1  single-cycle request to (re)load and start the countdown.
- interval  in  2  parameter index to load on start (0 arm, 1 driver, 2 passenger, 3 alarm-on).
- reprogram  in  1  write strobe for the parameter bank.
- time_param_sel  in  2  parameter index to write.
- time_value  in  4  new value in seconds (0..15).
- expired  out  1  one-cycle pulse at end of countdown.
- one_hz_enable  out  1  one-cycle tick every ONE_HZ_DIV cycles.
- busy  out  1  high while counting.
- remaining  out  4  seconds left in the current run.

Behaviour:
- Reset (synchronous, active-high; clock `clock`):
  - params[0..3] take the T_* defaults.
  - State IDLE; prescaler=0.
  - remaining=0, expired=0, busy=0.
  - Reset overrides `reprogram` and `start_timer` in the same cycle.
- Prescaler:
  - Counts 0..ONE_HZ_DIV-1 and wraps.
  - `one_hz_enable` = (prescaler == ONE_HZ_DIV-1), decoded combinationally from the register.
  - Cleared to 0 on every accepted start, so the first second is always full length.
- Parameter bank:
  - On an edge with reprogram=1, params[time_param_sel] <= time_value.
  - A write never alters a run in progress.
  - A write in the same cycle as a start for the same index: the start loads the OLD value.
- States: IDLE, COUNT, EXPIRE.
  - Any state, start_timer=1 at edge E0:
    - remaining <= params[interval] (call it V).
    - prescaler <= 0.
    - Next state COUNT if V>0, EXPIRE if V=0.
    - Restart while COUNT aborts the old run silently (no `expired`).
    - Start has priority over the tick and over EXPIRE.
  - COUNT, tick consumed at an edge:
    - remaining > 1: remaining--.
    - remaining == 1: remaining <= 0, next state EXPIRE.
  - EXPIRE: expired=1 for exactly one cycle, then IDLE.
  - IDLE: outputs hold; remaining=0 after an expiry.
- Outputs:
  - busy = (state == COUNT).
  - expired = (state == EXPIRE).
  - Both are state decodes with no extra latency.
- Latency: with V>0, `expired` is high in the cycle after edge E0 + V·ONE_HZ_DIV; with V=0, in the cycle after E0.
- `start_timer` held high re-triggers every cycle and never expires; the requester must pulse it.

Test Plan (ONE_HZ_DIV=4 unless stated):
1. Reset, then check outputs and the first tick → expired=0, busy=0, remaining=0; first one_hz_enable in the cycle after edge 3 post-reset; recurs every 4 cycles.
2. Default run: start pulse interval=0 at edge 10 → busy=1 from edge 10; remaining 6,5,…,1 stepping at edges 14,18,…; expired high for exactly the cycle after edge 34; busy=0 from that edge.
3. Reprogram and load: reprogram sel=3 value=2, then start interval=3 at edge 20 → expired after edge 28. Reprogram sel=1 value=0, then start interval=1 → expired in the very next cycle, busy never asserted.
4. Restart mid-run: start interval=2 (15), then start interval=0 at 9 s remaining → remaining reloads to 6, no expired pulse for the first run, single expired 24 cycles after the restart.
5. Collisions: reprogram sel=0 value=3 in the same cycle as start interval=0 → run lasts 6 s; the next run lasts 3 s. Reset asserted mid-COUNT → immediate IDLE, remaining=0, params back to defaults, no expired.
6. Start in EXPIRE cycle → new run accepted, expired still lasts exactly one cycle, busy=1 on the next cycle.
